ddr_csr_access_arb: RTL and testbench
=====================================

// Module: ddr_csr_access_arb
// PURPOSE
// - Shares the single DDR CTRL CSR register-file port (write/read/addr/wdata -> rdata/error/ready) between NREQ masters.
// - Typical masters: AHB slave bridge, JTAG/debug, internal training sequencer.
// - Round-robin arbitration, one transaction at a time, registered response with ready-timeout protection.
// - Sits between the requesters and the ddr_ctrl CSR block.
// PARAMETERS
// - NREQ     3   number of requesters (2..8)
// - AWIDTH   32  CSR address width
// - DWIDTH   32  CSR data width
// - TIMEOUT  16  max ACCESS cycles waiting for i_csr_ready before forced error (>=1)
// PORTS
// - i_hclk           in   1            CSR/AHB clock; single clock domain
// - i_hreset_n       in   1            asynchronous, active-low reset
// - i_req_valid      in   NREQ         request pending per master; must hold stable until o_req_ready
// - i_req_write      in   NREQ         1=write, 0=read
// - i_req_addr       in   NREQ*AWIDTH  packed addresses, master k at [k*AWIDTH +: AWIDTH]
// - i_req_wdata      in   NREQ*DWIDTH  packed write data
// - o_req_ready      out  NREQ         one-cycle accept pulse to the granted master
// - o_rsp_valid      out  NREQ         one-cycle response pulse to the owning master
// - o_rsp_rdata      out  DWIDTH       response read data (0 for writes), valid with o_rsp_valid
// - o_rsp_error      out  1            response error (decode error or timeout)
// - o_csr_write      out  1            to CSR block i_write
// - o_csr_read       out  1            to CSR block i_read
// - o_csr_addr       out  AWIDTH       to CSR block i_addr
// - o_csr_wdata      out  DWIDTH       to CSR block i_wdata
// - i_csr_rdata      in   DWIDTH       from CSR block o_rdata (combinational)
// - i_csr_error      in   1            from CSR block o_error
// - i_csr_ready      in   1            from CSR block o_ready
// - o_busy           out  1            state != IDLE
// - o_timeout_sticky out  1            set on any timeout, cleared only by reset
// BEHAVIOUR
// - Reset: state=IDLE, rr pointer=0 (master 0 highest priority), all outputs 0, latched request cleared, counter 0.
// - FSM IDLE: if |i_req_valid, pick first valid master at or after rr pointer (wrapping); o_req_ready[g]=1 this cycle;
//   latch write/addr/wdata/g; rr pointer <= (g+1)%NREQ; -> ACCESS. No valid -> stay, no outputs.
// - FSM ACCESS: drive o_csr_write or o_csr_read (exactly one) with latched addr/wdata; count cycles.
//   i_csr_ready=1 -> capture rdata (read: i_csr_rdata; write: 0), error=i_csr_error; -> RESP.
//   Else if count==TIMEOUT-1 -> rdata=0, error=1, set o_timeout_sticky; -> RESP. Strobes drop when leaving ACCESS.
// - FSM RESP: o_rsp_valid[g]=1 for exactly one cycle with registered rdata/error; -> IDLE.
// - Latency: accept cycle T, CSR strobe T+1 (ready=1), response T+2; back-to-back throughput 1 per 3 cycles.
// - o_csr_* are 0 outside ACCESS; o_rsp_rdata/o_rsp_error hold last value but are only meaningful with o_rsp_valid.
// - Fairness: master granted at T is lowest priority at next arbitration; with all NREQ valid, grants rotate 0,1,..,NREQ-1,0.
// - Requests arriving during ACCESS/RESP wait; no preemption; i_req_valid changes after accept are ignored.
// - Same-master re-request in the cycle after its RESP is legal and arbitrated normally.
// - Reset mid-transaction: aborts immediately, no response pulse issued; CSR strobes drop asynchronously.
// - Counter width $clog2(TIMEOUT)+1; never wraps (saturates at TIMEOUT-1 then state exits).
// STRUCTURE
// - ddr_global_pkg: typedef csr_req_t {write, addr, wdata}; typedef csr_arb_state_t {IDLE, ACCESS, RESP}.
// - Sub-module ddr_rr_arb #(N): combinational pick of first set bit from pointer, outputs one-hot grant + index.
// - Top holds FSM, request latch, timeout counter, response registers.
// TESTING
// - Single read: m1 reads ADDR=0x0 with CSR rdata=0x5 -> o_req_ready[1] at T, o_csr_read at T+1, o_rsp_valid[1] T+2, rdata=0x5, error=0.
// - Write: m0 writes 0xA5A5 to 0x0 -> o_csr_write one cycle with wdata=0xA5A5; rsp rdata=0, error=0.
// - Bad address: i_csr_error=1 -> rsp error=1, o_timeout_sticky stays 0.
// - All 3 valid continuously from reset -> grant order 0,1,2,0,1,2; each response to the matching master only.
// - i_csr_ready held 0 -> ACCESS lasts exactly TIMEOUT=16 cycles, rsp error=1, rdata=0, o_timeout_sticky=1.
// - i_hreset_n low during ACCESS -> strobes and o_busy 0 immediately, no o_rsp_valid, next grant starts at master 0.

Source files
------------

// File: rtl/ddr_global_pkg.sv
// ---------------------------------------------------------------------------
// ddr_global_pkg
// Shared types for the DDR controller CSR access path.
//   csr_arb_state_t : arbiter FSM states (IDLE / ACCESS / RESP)
//   csr_req_t       : request latched at grant time (write flag, addr, wdata)
//   rr_next()       : round-robin successor index with wrap
// No ports (package).
// ---------------------------------------------------------------------------
package ddr_global_pkg;

    // Widest address / data the latched request can carry.
    localparam int CSR_AWIDTH = 32;
    localparam int CSR_DWIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } csr_arb_state_t;

    typedef struct packed {
        logic                  write;
        logic [CSR_AWIDTH-1:0] addr;
        logic [CSR_DWIDTH-1:0] wdata;
    } csr_req_t;

    localparam csr_req_t CSR_REQ_NONE = '{
        write: 1'b0,
        addr:  {CSR_AWIDTH{1'b0}},
        wdata: {CSR_DWIDTH{1'b0}}
    };

    // Index of the master after idx, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/ddr_csr_access_arb_if.sv
// ---------------------------------------------------------------------------
// ddr_csr_access_arb_if
// Bundles the requester handshake and the CSR register-file port of the
// CSR access arbiter.
//   Requester side : i_req_valid/write/addr/wdata -> o_req_ready,
//                    o_rsp_valid/rdata/error
//   CSR side       : o_csr_write/read/addr/wdata -> i_csr_rdata/error/ready
// Modports:
//   slave  : the arbiter (consumes i_*, drives o_*)
//   master : the environment around it (requesters + CSR block)
// ---------------------------------------------------------------------------
interface ddr_csr_access_arb_if #(
    parameter int NREQ   = 3,
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic [NREQ-1:0]        i_req_valid;
    logic [NREQ-1:0]        i_req_write;
    logic [NREQ*AWIDTH-1:0] i_req_addr;
    logic [NREQ*DWIDTH-1:0] i_req_wdata;
    logic [NREQ-1:0]        o_req_ready;
    logic [NREQ-1:0]        o_rsp_valid;
    logic [DWIDTH-1:0]      o_rsp_rdata;
    logic                   o_rsp_error;
    logic                   o_csr_write;
    logic                   o_csr_read;
    logic [AWIDTH-1:0]      o_csr_addr;
    logic [DWIDTH-1:0]      o_csr_wdata;
    logic [DWIDTH-1:0]      i_csr_rdata;
    logic                   i_csr_error;
    logic                   i_csr_ready;

    modport slave (
        input  i_req_valid, i_req_write, i_req_addr, i_req_wdata,
        input  i_csr_rdata, i_csr_error, i_csr_ready,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_error,
        output o_csr_write, o_csr_read, o_csr_addr, o_csr_wdata
    );

    modport master (
        output i_req_valid, i_req_write, i_req_addr, i_req_wdata,
        output i_csr_rdata, i_csr_error, i_csr_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_error,
        input  o_csr_write, o_csr_read, o_csr_addr, o_csr_wdata
    );
endinterface

// File: rtl/ddr_rr_arb.sv
// ---------------------------------------------------------------------------
// ddr_rr_arb
// Combinational round-robin pick: first set request bit at or after the
// priority pointer, wrapping past N-1 back to 0.
//   i_req     : request vector
//   i_ptr     : index holding highest priority
//   o_gnt     : one-hot grant (all zero when no request)
//   o_gnt_idx : binary index of the granted bit
//   o_gnt_any : any request present
// ---------------------------------------------------------------------------
module ddr_rr_arb #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_gnt_any
);
    logic [IW:0]   sum_s;
    logic [IW-1:0] idx_s;

    // Scan from the pointer outward; the first hit wins, later hits are ignored.
    always_comb begin
        o_gnt     = {N{1'b0}};
        o_gnt_idx = {IW{1'b0}};
        o_gnt_any = 1'b0;
        sum_s     = {(IW+1){1'b0}};
        idx_s     = {IW{1'b0}};
        for (int k = 0; k < N; k++) begin
            sum_s = {1'b0, i_ptr} + (IW+1)'(k);
            idx_s = (sum_s >= (IW+1)'(N)) ? IW'(sum_s - (IW+1)'(N)) : sum_s[IW-1:0];
            if (i_req[idx_s] && !o_gnt_any) begin
                o_gnt[idx_s] = 1'b1;
                o_gnt_idx    = idx_s;
                o_gnt_any    = 1'b1;
            end else begin
                o_gnt_any    = o_gnt_any;
            end
        end
    end
endmodule

// File: rtl/ddr_csr_access_arb.sv
// ---------------------------------------------------------------------------
// ddr_csr_access_arb
// Shares the single DDR controller CSR port between NREQ masters with
// round-robin arbitration, one transaction at a time.
// Accept at T (combinational o_req_ready), CSR strobe from T+1 until the CSR
// block answers or TIMEOUT cycles pass, one-cycle response pulse after that.
// Ports:
//   i_hclk            : clock
//   i_hreset_n        : asynchronous active-low reset
//   bus (slave)       : requester handshake + CSR register-file port
//   o_busy            : a transaction is in flight (state != IDLE)
//   o_timeout_sticky  : some access has timed out since reset
// ---------------------------------------------------------------------------
module ddr_csr_access_arb
    import ddr_global_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 i_hclk,
    input  logic                 i_hreset_n,
    ddr_csr_access_arb_if.slave  bus,
    output logic                 o_busy,
    output logic                 o_timeout_sticky
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    csr_arb_state_t    state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    csr_req_t          req_q, req_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              csr_write_q, csr_write_d;
    logic              csr_read_q, csr_read_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;
    logic              sticky_q, sticky_d;

    logic [NREQ-1:0]   gnt_s;
    logic [IW-1:0]     gnt_idx_s;
    logic              gnt_any_s;
    logic [NREQ-1:0]   req_ready_s;
    logic [NREQ-1:0]   owner_onehot_s;

    logic [AWIDTH-1:0] req_addr_a  [NREQ];
    logic [DWIDTH-1:0] req_wdata_a [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign req_addr_a[k]  = bus.i_req_addr[k*AWIDTH +: AWIDTH];
        assign req_wdata_a[k] = bus.i_req_wdata[k*DWIDTH +: DWIDTH];
    end

    ddr_rr_arb #(.N(NREQ), .IW(IW)) u_rr_arb (
        .i_req     (bus.i_req_valid),
        .i_ptr     (ptr_q),
        .o_gnt     (gnt_s),
        .o_gnt_idx (gnt_idx_s),
        .o_gnt_any (gnt_any_s)
    );

    assign owner_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << gidx_q;

    // Next-state, request latch, timeout counter and response capture.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        csr_write_d = csr_write_q;
        csr_read_d  = csr_read_q;
        rsp_valid_d = {NREQ{1'b0}};
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        sticky_d    = sticky_q;
        req_ready_s = {NREQ{1'b0}};
        case (state_q)
            IDLE: begin
                if (gnt_any_s) begin
                    req_ready_s = gnt_s;
                    req_d.write = bus.i_req_write[gnt_idx_s];
                    req_d.addr  = CSR_AWIDTH'(req_addr_a[gnt_idx_s]);
                    req_d.wdata = CSR_DWIDTH'(req_wdata_a[gnt_idx_s]);
                    gidx_d      = gnt_idx_s;
                    // The master just served drops to lowest priority.
                    ptr_d       = IW'(rr_next(32'(gnt_idx_s), 32'(NREQ)));
                    cnt_d       = {CW{1'b0}};
                    csr_write_d = bus.i_req_write[gnt_idx_s];
                    csr_read_d  = !bus.i_req_write[gnt_idx_s];
                    state_d     = ACCESS;
                end else begin
                    state_d     = IDLE;
                end
            end
            ACCESS: begin
                // A ready on the last allowed cycle still wins over the timeout.
                if (bus.i_csr_ready) begin
                    rsp_rdata_d = req_q.write ? {DWIDTH{1'b0}} : bus.i_csr_rdata;
                    rsp_error_d = bus.i_csr_error;
                    rsp_valid_d = owner_onehot_s;
                    req_d       = CSR_REQ_NONE;
                    cnt_d       = {CW{1'b0}};
                    csr_write_d = 1'b0;
                    csr_read_d  = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_rdata_d = {DWIDTH{1'b0}};
                    rsp_error_d = 1'b1;
                    sticky_d    = 1'b1;
                    rsp_valid_d = owner_onehot_s;
                    req_d       = CSR_REQ_NONE;
                    cnt_d       = {CW{1'b0}};
                    csr_write_d = 1'b0;
                    csr_read_d  = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_d       = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                req_d       = CSR_REQ_NONE;
                cnt_d       = {CW{1'b0}};
                csr_write_d = 1'b0;
                csr_read_d  = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            state_q     <= IDLE;
            ptr_q       <= {IW{1'b0}};
            gidx_q      <= {IW{1'b0}};
            req_q       <= CSR_REQ_NONE;
            cnt_q       <= {CW{1'b0}};
            csr_write_q <= 1'b0;
            csr_read_q  <= 1'b0;
            rsp_valid_q <= {NREQ{1'b0}};
            rsp_rdata_q <= {DWIDTH{1'b0}};
            rsp_error_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            csr_write_q <= csr_write_d;
            csr_read_q  <= csr_read_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            sticky_q    <= sticky_d;
        end
    end

    // The latch is cleared outside ACCESS, so addr/wdata read as 0 there.
    assign bus.o_req_ready  = req_ready_s;
    assign bus.o_rsp_valid  = rsp_valid_q;
    assign bus.o_rsp_rdata  = rsp_rdata_q;
    assign bus.o_rsp_error  = rsp_error_q;
    assign bus.o_csr_write  = csr_write_q;
    assign bus.o_csr_read   = csr_read_q;
    assign bus.o_csr_addr   = req_q.addr[AWIDTH-1:0];
    assign bus.o_csr_wdata  = req_q.wdata[DWIDTH-1:0];
    assign o_busy           = (state_q != IDLE);
    assign o_timeout_sticky = sticky_q;

endmodule

// File: tb/tb_ddr_csr_access_arb.sv
// ---------------------------------------------------------------------------
// tb_ddr_csr_access_arb
// Self-checking bench for ddr_csr_access_arb. A transaction-level model keeps
// a round-robin pointer and, per accepted transaction, the cycle numbers at
// which the CSR strobe, timeout and response must appear.
// ---------------------------------------------------------------------------
module tb_ddr_csr_access_arb;
    localparam int NREQ    = 3;
    localparam int AWIDTH  = 32;
    localparam int DWIDTH  = 32;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic sticky;

    ddr_csr_access_arb_if #(.NREQ(NREQ), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) bus ();

    ddr_csr_access_arb #(.NREQ(NREQ), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .TIMEOUT(TIMEOUT)) dut (
        .i_hclk           (clk),
        .i_hreset_n       (rst_n),
        .bus              (bus),
        .o_busy           (busy),
        .o_timeout_sticky (sticky)
    );

    always #5 clk = ~clk;

    int n_vec    = 0;
    int n_miscmp = 0;

    // Requester state driven by the bench.
    bit          m_valid [NREQ];
    bit          m_write [NREQ];
    logic [31:0] m_addr  [NREQ];
    logic [31:0] m_wdata [NREQ];
    int          mode    = 0;   // 0: directed only, 1: random requests, 2: all masters always requesting
    int          force_d = -1;
    int          force_err = -1;

    // Model: cycle count, rr pointer, current transaction timeline.
    int          cyc = 0;
    int          ptr_m = 0;
    bit          act = 1'b0;
    int          c_g, c_start, c_accend, c_resp, c_d;
    bit          c_wr, c_to, c_err;
    logic [31:0] c_addr, c_wdata;
    bit          sticky_m = 1'b0;

    logic [NREQ-1:0] e_ready, e_rspv;
    bit              e_wr, e_rd, e_busy, e_err;
    logic [31:0]     e_addr, e_wdata, e_rdata;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // What the CSR block returns for a read of addr.
    function automatic logic [31:0] csr_value(input logic [31:0] addr);
        return (addr == 32'h0) ? 32'h5 : ((addr * 32'd3) ^ 32'hC3C3_5A5A);
    endfunction

    function automatic int pick_delay();
        int r;
        if (force_d >= 0) return force_d;
        r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 3);
        if (r < 8) return $urandom_range(4, TIMEOUT - 1);
        return TIMEOUT + $urandom_range(0, 3);
    endfunction

    task automatic new_req(input int m);
        m_valid[m] = 1'b1;
        m_write[m] = 1'($urandom_range(0, 1));
        m_addr[m]  = $urandom & 32'hFFFF_FFFC;
        m_wdata[m] = $urandom;
    endtask

    task automatic drive_req();
        for (int k = 0; k < NREQ; k++) begin
            bus.i_req_valid[k]                  = m_valid[k];
            bus.i_req_write[k]                  = m_write[k];
            bus.i_req_addr[k*AWIDTH +: AWIDTH]  = m_addr[k];
            bus.i_req_wdata[k*DWIDTH +: DWIDTH] = m_wdata[k];
        end
    endtask

    task automatic clear_masters();
        for (int k = 0; k < NREQ; k++) begin
            m_valid[k] = 1'b0; m_write[k] = 1'b0; m_addr[k] = 32'h0; m_wdata[k] = 32'h0;
        end
        drive_req();
    endtask

    // Called just after a rising edge: arbitrate, drive inputs, compute expectations.
    task automatic prep_cycle();
        int  g;
        bit  in_acc, hit;
        if (act && cyc > c_resp) act = 1'b0;
        e_ready = '0;
        if (!act) begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (ptr_m + k) % NREQ;
                if (g < 0 && m_valid[idx]) g = idx;
            end
            if (g >= 0) begin
                e_ready[g] = 1'b1;
                ptr_m      = (g + 1) % NREQ;
                act        = 1'b1;
                c_g        = g;
                c_wr       = m_write[g];
                c_addr     = m_addr[g];
                c_wdata    = m_wdata[g];
                c_start    = cyc + 1;
                c_d        = pick_delay();
                c_err      = (force_err >= 0) ? (force_err != 0) : ($urandom_range(0, 3) == 0);
                c_to       = (c_d >= TIMEOUT);
                c_accend   = c_start + (c_to ? TIMEOUT - 1 : c_d);
                c_resp     = c_accend + 1;
            end
        end
        drive_req();
        if (act && c_to && cyc >= c_resp) sticky_m = 1'b1;
        in_acc = act && cyc >= c_start && cyc <= c_accend;
        hit    = in_acc && !c_to && (cyc == c_start + c_d);
        bus.i_csr_ready = in_acc ? hit : 1'($urandom_range(0, 1));
        bus.i_csr_rdata = hit ? csr_value(c_addr) : $urandom;
        bus.i_csr_error = hit ? c_err : 1'($urandom_range(0, 1));
        e_wr    = in_acc && c_wr;
        e_rd    = in_acc && !c_wr;
        e_addr  = in_acc ? c_addr : 32'h0;
        e_wdata = in_acc ? c_wdata : 32'h0;
        e_busy  = act && cyc >= c_start && cyc <= c_resp;
        e_rspv  = (act && cyc == c_resp) ? (NREQ'(1) << c_g) : '0;
        e_rdata = (c_to || c_wr) ? 32'h0 : csr_value(c_addr);
        e_err   = c_to ? 1'b1 : c_err;
    endtask

    task automatic check_cycle();
        check_val("req_ready", bus.o_req_ready, e_ready);
        check_val("csr_write", bus.o_csr_write, e_wr);
        check_val("csr_read",  bus.o_csr_read,  e_rd);
        check_val("csr_addr",  bus.o_csr_addr,  e_addr);
        check_val("csr_wdata", bus.o_csr_wdata, e_wdata);
        check_val("rsp_valid", bus.o_rsp_valid, e_rspv);
        check_val("busy",      busy,            e_busy);
        check_val("sticky",    sticky,          sticky_m);
        if (e_rspv != '0) begin
            check_val("rsp_rdata", bus.o_rsp_rdata, e_rdata);
            check_val("rsp_error", bus.o_rsp_error, e_err);
        end
    endtask

    task automatic advance();
        for (int k = 0; k < NREQ; k++) begin
            if (e_ready[k]) begin
                m_valid[k] = 1'b0;
                if (mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1)) new_req(k);
            end else if (!m_valid[k]) begin
                if (mode == 2 || (mode == 1 && $urandom_range(0, 3) == 0)) new_req(k);
            end
        end
        cyc++;
    endtask

    task automatic do_cycle();
        prep_cycle();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        advance();
    endtask

    task automatic single(input int m, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input int d, input int err);
        int n;
        mode = 0; force_d = d; force_err = err;
        m_valid[m] = 1'b1; m_write[m] = wr; m_addr[m] = a; m_wdata[m] = wd;
        n = 0;
        do begin
            do_cycle();
            n++;
        end while ((m_valid[m] || (act && cyc <= c_resp)) && n < 60);
        if (n >= 60) check_val("single_budget", 64'(n), 64'd59);
        force_d = -1; force_err = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        rst_n = 1'b0;
        clear_masters();
        bus.i_csr_ready = 1'b0; bus.i_csr_rdata = 32'h0; bus.i_csr_error = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_req_ready", bus.o_req_ready, 3'b000);
        check_val("rst_rsp_valid", bus.o_rsp_valid, 3'b000);
        check_val("rst_rsp_rdata", bus.o_rsp_rdata, 32'h0);
        check_val("rst_rsp_error", bus.o_rsp_error, 1'b0);
        check_val("rst_csr_write", bus.o_csr_write, 1'b0);
        check_val("rst_csr_read",  bus.o_csr_read,  1'b0);
        check_val("rst_csr_addr",  bus.o_csr_addr,  32'h0);
        check_val("rst_busy",      busy,            1'b0);
        check_val("rst_sticky",    sticky,          1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed: read, write, decode error, ready on last cycle, timeout.
        single(1, 1'b0, 32'h0000_0000, 32'h0,         0,           0);
        single(0, 1'b1, 32'h0000_0000, 32'h0000_A5A5, 0,           0);
        single(2, 1'b0, 32'h0000_0100, 32'h0,         1,           1);
        single(1, 1'b0, 32'h0000_0044, 32'h0,         TIMEOUT - 1, 0);
        single(0, 1'b0, 32'h0000_0040, 32'h0,         TIMEOUT + 2, 0);

        // All masters requesting with an immediately-ready CSR block.
        mode = 2; force_d = 0;
        repeat (18) do_cycle();
        force_d = -1;

        // Random traffic.
        mode = 1;
        repeat (3000) do_cycle();

        // Reset while an access is in flight.
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            prep_cycle();
            if (act && cyc >= c_start && cyc <= c_accend) begin
                found = 1'b1;
            end else begin
                @(negedge clk);
                check_cycle();
                @(posedge clk);
                #1;
                advance();
            end
        end
        if (!found) begin
            check_val("abort_reach", 64'd0, 64'd1);
        end else begin
            #2;
            rst_n = 1'b0;
            #1;
            check_val("abort_csr_write", bus.o_csr_write, 1'b0);
            check_val("abort_csr_read",  bus.o_csr_read,  1'b0);
            check_val("abort_busy",      busy,            1'b0);
            check_val("abort_rsp_valid", bus.o_rsp_valid, 3'b000);
            clear_masters();
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            check_val("abort_rsp_hold", bus.o_rsp_valid, 3'b000);
            check_val("abort_sticky",   sticky,          1'b0);
            rst_n    = 1'b1;
            act      = 1'b0;
            ptr_m    = 0;
            sticky_m = 1'b0;
            e_ready  = '0;
            @(posedge clk);
            #1;
            cyc++;
        end

        // From reset with everyone requesting: grants must restart at master 0.
        mode = 2; force_d = 0;
        repeat (12) do_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
